// File: rtl/payment_checker.sv
// Coin-payment controller: latches a drink selection, accumulates coins,
// rejects invalid coins, and either vends (with optional change) or refunds.
// All outputs come straight from registers.
module payment_checker #(
    parameter int                            SEL_W        = 2,
    parameter int                            SUM_W        = 5,
    parameter logic [(2**SEL_W)*SUM_W-1:0]   PRICE_TABLE  = {5'd10, 5'd5, 5'd4, 5'd2},
    parameter logic [SUM_W-1:0]              INV_CODE     = 5'b11111,
    parameter bit                            ALLOW_CHANGE = 1'b1,
    parameter int                            TIMEOUT      = 1000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [SEL_W-1:0] bebida,
    input  logic             coin_valid,
    input  logic [SUM_W-1:0] coin_val,
    input  logic             cancel,
    output logic             moedaINV,
    output logic             moedaNCORRESPONDE,
    output logic             coin_ack,
    output logic             vend,
    output logic             refund,
    output logic [SUM_W-1:0] change,
    output logic             change_valid,
    output logic [SUM_W-1:0] soma,
    output logic             busy
);

    localparam int                N_PROD   = 2**SEL_W;
    localparam int                TMR_W    = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [SUM_W:0]    SUM_MAX  = {1'b0, {SUM_W{1'b1}}};

    typedef enum logic [1:0] {IDLE, COLLECT, VEND, REFUND} state_t;

    state_t           state_reg, state_next;
    logic [SUM_W-1:0] price_reg, price_next;
    logic [SUM_W-1:0] soma_reg, soma_next;
    logic [SUM_W-1:0] change_reg, change_next;
    logic [TMR_W-1:0] timer_reg, timer_next;
    logic             minv_reg, minv_next;
    logic             mnc_reg, mnc_next;
    logic             ack_reg, ack_next;
    logic             vend_reg, vend_next;
    logic             refund_reg, refund_next;
    logic             cv_reg, cv_next;
    logic             busy_reg, busy_next;

    // Unpack the price table into one entry per product
    logic [SUM_W-1:0] price_rom [N_PROD];
    genvar gi;
    generate
        for (gi = 0; gi < N_PROD; gi++) begin : g_price
            assign price_rom[gi] = PRICE_TABLE[gi*SUM_W +: SUM_W];
        end
    endgenerate

    // Credit arithmetic is one bit wider so overpayment beyond the credit range is visible
    logic [SUM_W:0]   sum_new;
    logic [SUM_W:0]   diff_new;
    logic [SUM_W-1:0] sum_sat;
    logic [SUM_W-1:0] diff_sat;
    logic             coin_bad;

    assign sum_new  = {1'b0, soma_reg} + {1'b0, coin_val};
    assign diff_new = sum_new - {1'b0, price_reg};
    assign sum_sat  = (sum_new  > SUM_MAX) ? SUM_MAX[SUM_W-1:0] : sum_new[SUM_W-1:0];
    assign diff_sat = (diff_new > SUM_MAX) ? SUM_MAX[SUM_W-1:0] : diff_new[SUM_W-1:0];
    assign coin_bad = (coin_val == INV_CODE) || (coin_val == '0);

    // State and datapath registers; reset drops any held credit silently
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            price_reg  <= '0;
            soma_reg   <= '0;
            change_reg <= '0;
            timer_reg  <= '0;
            minv_reg   <= 1'b0;
            mnc_reg    <= 1'b0;
            ack_reg    <= 1'b0;
            vend_reg   <= 1'b0;
            refund_reg <= 1'b0;
            cv_reg     <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            price_reg  <= price_next;
            soma_reg   <= soma_next;
            change_reg <= change_next;
            timer_reg  <= timer_next;
            minv_reg   <= minv_next;
            mnc_reg    <= mnc_next;
            ack_reg    <= ack_next;
            vend_reg   <= vend_next;
            refund_reg <= refund_next;
            cv_reg     <= cv_next;
            busy_reg   <= busy_next;
        end
    end

    // Next-state and next-output decode; cancel beats timeout beats coins in COLLECT
    always_comb begin
        state_next  = state_reg;
        price_next  = price_reg;
        soma_next   = soma_reg;
        change_next = change_reg;
        timer_next  = timer_reg;
        minv_next   = 1'b0;
        mnc_next    = 1'b0;
        ack_next    = 1'b0;
        vend_next   = 1'b0;
        refund_next = 1'b0;
        cv_next     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (coin_valid) begin
                    minv_next = 1'b1;
                end
                if (start) begin
                    price_next  = price_rom[bebida];
                    soma_next   = '0;
                    timer_next  = '0;
                    change_next = '0;
                    state_next  = COLLECT;
                end
            end
            COLLECT: begin
                if (cancel || (timer_reg == TMR_LAST)) begin
                    state_next = REFUND;
                end else begin
                    timer_next = timer_reg + 1'b1;
                    if (coin_valid) begin
                        if (coin_bad) begin
                            minv_next = 1'b1;
                        end else begin
                            ack_next  = 1'b1;
                            soma_next = sum_sat;
                            if (sum_new < {1'b0, price_reg}) begin
                                timer_next = '0;
                            end else if (sum_new == {1'b0, price_reg}) begin
                                change_next = '0;
                                state_next  = VEND;
                            end else if (ALLOW_CHANGE) begin
                                change_next = diff_sat;
                                state_next  = VEND;
                            end else begin
                                mnc_next   = 1'b1;
                                state_next = REFUND;
                            end
                        end
                    end
                end
            end
            VEND: begin
                vend_next  = 1'b1;
                cv_next    = (change_reg != '0);
                soma_next  = '0;
                state_next = IDLE;
            end
            REFUND: begin
                refund_next = 1'b1;
                change_next = soma_reg;
                cv_next     = (soma_reg != '0);
                soma_next   = '0;
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    assign moedaINV          = minv_reg;
    assign moedaNCORRESPONDE = mnc_reg;
    assign coin_ack          = ack_reg;
    assign vend              = vend_reg;
    assign refund            = refund_reg;
    assign change            = change_reg;
    assign change_valid      = cv_reg;
    assign soma              = soma_reg;
    assign busy              = busy_reg;

endmodule
